// File: rtl/tick_generator.sv
// Programmable enable-pulse generator: a reloadable base prescaler feeding NUM_CH
// binary-cascaded tick channels, each with a square-wave blink output.
module tick_generator #(
    parameter int CNT_W          = 27,
    parameter int DEFAULT_PERIOD = 50_000_000,
    parameter int NUM_CH         = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic [CNT_W-1:0]  period_in,
    input  logic              period_wr,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] blink,
    output logic [CNT_W-1:0]  count,
    output logic              period_err
);

    localparam logic [CNT_W-1:0] DEF_P = CNT_W'(DEFAULT_PERIOD);

    logic [CNT_W-1:0]  shadow;
    logic [CNT_W-1:0]  active;
    logic [NUM_CH-1:0] tick_cnt;
    logic [NUM_CH-1:0] fire;
    logic              reload;

    // Channel k fires when the low k bits of the pre-increment tick count are all ones.
    assign fire[0] = 1'b1;
    for (genvar k = 1; k < NUM_CH; k++) begin : g_fire
        assign fire[k] = &tick_cnt[k-1:0];
    end

    assign reload = (count == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= DEF_P - CNT_W'(1);
            shadow     <= DEF_P;
            active     <= DEF_P;
            tick       <= '0;
            blink      <= '0;
            tick_cnt   <= '0;
            period_err <= 1'b0;
        end else begin
            if (clr) begin
                count      <= shadow - CNT_W'(1);
                active     <= shadow;
                tick_cnt   <= '0;
                blink      <= '0;
                tick       <= '0;
                period_err <= 1'b0;
            end else if (en) begin
                if (!reload) begin
                    count <= count - CNT_W'(1);
                    tick  <= '0;
                end else begin
                    count    <= shadow - CNT_W'(1);
                    active   <= shadow;
                    tick     <= fire;
                    blink    <= blink ^ fire;
                    tick_cnt <= tick_cnt + NUM_CH'(1);
                end
            end else begin
                tick <= '0;
            end
            // Shadow writes land after this edge's reload/clr, so those use the old value;
            // a zero write setting the error flag overrides clr's clear.
            if (period_wr) begin
                if (period_in != '0) begin
                    shadow <= period_in;
                end else begin
                    period_err <= 1'b1;
                end
            end
        end
    end

    // The prescaler never exceeds the period it is currently counting out.
    a_count_in_period: assert property (@(posedge clk) disable iff (rst) count < active);

endmodule

// File: tb/tb_tick_generator.sv
// Randomized bench for tick_generator against a tick-number based reference model.
module tb_tick_generator;
  localparam int CNT_W = 8;
  localparam int DP    = 10;
  localparam int NCH   = 3;

  logic             clk = 1'b0;
  logic             rst, en, clr, period_wr;
  logic [CNT_W-1:0] period_in;
  logic [NCH-1:0]   tick, blink;
  logic [CNT_W-1:0] count;
  logic             period_err;

  always #5 clk = ~clk;

  tick_generator #(.CNT_W(CNT_W), .DEFAULT_PERIOD(DP), .NUM_CH(NCH)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .period_in(period_in),
    .period_wr(period_wr), .tick(tick), .blink(blink), .count(count),
    .period_err(period_err)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  logic [31:0] exp_q[$];

  // Reference: edges remaining in the period, pending period, and the number of base
  // ticks since the last restart. Channel/blink state follows from that tick number.
  int m_rem, m_shadow, m_n;
  bit m_fired, m_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d, t=%0t)", tag, obs, exp, cyc, $time);
    end
  endtask

  function automatic logic [NCH-1:0] exp_tick();
    logic [NCH-1:0] t;
    t = '0;
    for (int k = 0; k < NCH; k++) t[k] = m_fired && ((m_n % (1 << k)) == 0);
    return t;
  endfunction

  function automatic logic [NCH-1:0] exp_blink();
    logic [NCH-1:0] b;
    b = '0;
    for (int k = 0; k < NCH; k++) b[k] = ((m_n >> (k + 1)) % 2 == 1) ^ ((m_n >> k) % 2 == 1) ^ ((m_n >> (k + 1)) % 2 == 1);
    return b;
  endfunction

  task automatic model_step();
    m_fired = 1'b0;
    if (rst) begin
      m_rem = DP - 1; m_shadow = DP; m_n = 0; m_err = 1'b0;
    end else begin
      if (clr) begin
        m_rem = m_shadow - 1; m_n = 0; m_err = 1'b0;
      end else if (en) begin
        if (m_rem != 0) m_rem--;
        else begin
          m_rem = m_shadow - 1; m_n++; m_fired = 1'b1;
        end
      end
      if (period_wr) begin
        if (period_in != 0) m_shadow = period_in;
        else m_err = 1'b1;
      end
    end
  endtask

  task automatic check_outputs();
    check("tick", 32'(tick), 32'(exp_tick()));
    check("blink", 32'(blink), 32'(exp_blink()));
    check("count", 32'(count), 32'(m_rem));
    check("period_err", 32'(period_err), 32'(m_err));
  endtask

  task automatic cycle(input bit r, input bit e, input bit c, input bit pw,
                       input logic [CNT_W-1:0] pi);
    rst = r; en = e; clr = c; period_wr = pw; period_in = pi;
    @(posedge clk);
    model_step();
    cyc = r ? 0 : cyc + 1;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    cycle(1, 1, 0, 0, '0);
    cycle(1, 1, 0, 0, '0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0; period_wr = 1'b0; period_in = '0;
    @(negedge clk);

    // Reset state and base/cascaded tick placement.
    do_reset();
    check("rst_tick", 32'(tick), 0);
    check("rst_count", 32'(count), DP - 1);
    check("rst_err", 32'(period_err), 0);
    exp_q.push_back(10); exp_q.push_back(20); exp_q.push_back(30); exp_q.push_back(40);
    for (int i = 0; i < 45; i++) begin
      cycle(0, 1, 0, 0, '0);
      if (tick[0]) begin
        if (exp_q.size() == 0) check("tick0_extra", cyc, 0);
        else check("tick0_time", cyc, exp_q.pop_front());
      end
      if (cyc == 20) check("tick_c20", 32'(tick), 3'b011);
      if (cyc == 40) check("tick_c40", 32'(tick), 3'b111);
    end
    check("tick0_missing", exp_q.size(), 0);

    // Period change mid-period completes the current period first.
    do_reset();
    for (int i = 1; i <= 35; i++) begin
      cycle(0, 1, 0, i == 13, 8'd4);
      if (cyc == 20) check("count_after_reload", 32'(count), 3);
      if (cyc == 24) check("tick0_at_24", 32'(tick[0]), 1);
    end

    // Pause shifts ticks without losing any.
    do_reset();
    for (int i = 1; i <= 45; i++) begin
      cycle(0, !(i >= 15 && i <= 24), 0, 0, '0);
      if (cyc == 30) check("tick0_after_pause", 32'(tick[0]), 1);
    end

    // Zero period write, then clr.
    do_reset();
    for (int i = 1; i <= 30; i++) cycle(0, 1, i == 15, i == 5, '0);
    check("err_cleared", 32'(period_err), 0);

    // Period 1 written on the reload edge, tick count wraps.
    do_reset();
    for (int i = 1; i <= 40; i++) cycle(0, 1, 0, i == 10, 8'd1);

    // Mid-period reset.
    do_reset();
    for (int i = 1; i <= 4; i++) cycle(0, 1, 0, 0, '0);
    cycle(1, 1, 0, 0, '0);
    check("midrst_count", 32'(count), DP - 1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0,
            $urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0,
            CNT_W'($urandom_range(0, 7)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
